// File: rtl/txuart_if.sv
// Byte-stream handshake plus serial-line status between host logic and the UART transmitter.
// Signals: transmit/tx_byte (host to TX), tx/tx_ready/is_transmitting/tx_done (TX to host).
interface txuart_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       tx;
  logic       tx_ready;
  logic       is_transmitting;
  logic       tx_done;

  modport master (
    output transmit, tx_byte,
    input  tx, tx_ready, is_transmitting, tx_done
  );

  modport slave (
    input  transmit, tx_byte,
    output tx, tx_ready, is_transmitting, tx_done
  );
endinterface

// File: rtl/txuart_buffered.sv
// Buffered 8N1/8N2 UART transmitter: one holding byte in front of the shifter.
// Ports: clk, rst (async, high), bus_if (slave: transmit/tx_byte in; tx/tx_ready/is_transmitting/tx_done out).
module txuart_buffered #(
  parameter int CLOCK_DIVIDE = 312,
  parameter int STOP_BITS    = 1
) (
  input logic     clk,
  input logic     rst,
  txuart_if.slave bus_if
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_e;

  localparam logic [10:0] PMAX  = 11'(CLOCK_DIVIDE - 1);
  localparam logic [2:0]  SLAST = 3'(4 * STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [10:0] presc_q, presc_d;
  logic [2:0]  tick_q, tick_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  logic        tx_q, tx_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick, bit_end, stop_end, load;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    hold_d   = hold_q;
    full_d   = full_q;
    load     = 1'b0;
    tick     = (presc_q == PMAX);
    bit_end  = tick && (tick_q == 3'd3);
    stop_end = tick && (tick_q == SLAST);

    if (state_q != TX_IDLE) begin
      presc_d = tick ? 11'd0 : presc_q + 11'd1;
      if (tick) tick_d = tick_q + 3'd1;
    end

    unique case (state_q)
      TX_IDLE: begin
        if (full_q) load = 1'b1;
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          tick_d  = 3'd0;
          bit_d   = 4'd8;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          tick_d  = 3'd0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q - 4'd1;
          if (bit_q == 4'd1) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (stop_end) begin
          tick_d = 3'd0;
          if (full_q) load = 1'b1;
          else state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Holding drains into the shifter; the start bit's prescaler restarts at 0.
    if (load) begin
      state_d = TX_START;
      shift_d = hold_q;
      presc_d = 11'd0;
      tick_d  = 3'd0;
      full_d  = 1'b0;
    end

    if (bus_if.transmit && rdy_q) begin
      hold_d = bus_if.tx_byte;
      full_d = 1'b1;
    end

    // Outputs are registered from next-state so they line up with the frame.
    unique case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    rdy_d  = !full_d;
    busy_d = (state_d != TX_IDLE);
    done_d = (state_d == TX_STOP) && (presc_d == PMAX)
             && (tick_d == SLAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      presc_q <= 11'd0;
      tick_q  <= 3'd0;
      bit_q   <= 4'd0;
      shift_q <= 8'd0;
      hold_q  <= 8'd0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus_if.tx              = tx_q;
  assign bus_if.tx_ready        = rdy_q;
  assign bus_if.is_transmitting = busy_q;
  assign bus_if.tx_done         = done_q;

endmodule

// File: tb/tb_txuart_buffered.sv
// Scoreboard bench: drivers queue expected frames, monitors check the serial line.
// Two instances: CLOCK_DIVIDE=2 with one stop bit, and with two stop bits.
module tb_txuart_buffered;

  localparam int BP = 8;

  typedef struct {
    logic [7:0] b;
    int         a;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst_r = 2'b11;
  logic [1:0] trans_r = 2'b00;
  logic [7:0] byte_r [2];
  logic [1:0] tx_w, rdy_w, ist_w, done_w;
  bit   [1:0] act_m = 2'b00;
  int         cyc = 0;
  int         vec = 0;
  int         err = 0;
  exp_t       q0[$];
  exp_t       q1[$];

  txuart_if b0 ();
  txuart_if b1 ();

  assign b0.transmit = trans_r[0];
  assign b0.tx_byte  = byte_r[0];
  assign b1.transmit = trans_r[1];
  assign b1.tx_byte  = byte_r[1];
  assign tx_w   = {b1.tx, b0.tx};
  assign rdy_w  = {b1.tx_ready, b0.tx_ready};
  assign ist_w  = {b1.is_transmitting, b0.is_transmitting};
  assign done_w = {b1.tx_done, b0.tx_done};

  txuart_buffered #(.CLOCK_DIVIDE(2), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst_r[0]), .bus_if(b0.slave)
  );
  txuart_buffered #(.CLOCK_DIVIDE(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst_r[1]), .bus_if(b1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int n;
    n = k / BP;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    return 1'b1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: frame is start, 8 data LSB-first, stop bits; each bit BP clocks.
  // Start cycle is the later of accept+1 and the cycle after the previous frame.
  task automatic monitor(input int d);
    exp_t       e;
    int         k, pend, es, len;
    bit         chk;
    logic [7:0] rx;
    logic       eb;
    k = 0; pend = 0; chk = 0; rx = 8'h00;
    e.b = 8'h00; e.a = 0;
    len = (d == 0) ? 10 * BP : 11 * BP;
    forever begin
      @(negedge clk);
      if (rst_w(d)) begin
        act_m[d] = 1'b0;
        pend = cyc;
        continue;
      end
      if (!act_m[d]) begin
        if (tx_w[d] == 1'b0) begin
          vec++;
          k = 0; rx = 8'h00; act_m[d] = 1'b1;
          if (qsize(d) == 0) begin
            err++; chk = 0;
            $display("FAIL unexpected_frame dut%0d cycle %0d: got start bit, required none", d, cyc);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            es = (e.a + 1 > pend + 1) ? e.a + 1 : pend + 1;
            chk = 1;
            if (cyc != es) begin
              err++;
              $display("FAIL start_cycle dut%0d: got %0d, required %0d", d, cyc, es);
            end
          end
        end else begin
          vec++;
          if (ist_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
            err++;
            $display("FAIL idle_out dut%0d cycle %0d: is_tx=%b done=%b, required 0 0",
                     d, cyc, ist_w[d], done_w[d]);
          end
          if (qsize(d) > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            es = (e.a + 1 > pend + 1) ? e.a + 1 : pend + 1;
            if (cyc > es) begin
              vec++; err++;
              $display("FAIL start_late dut%0d byte %h: no start by cycle %0d", d, e.b, es);
              if (d == 0) void'(q0.pop_front());
              else void'(q1.pop_front());
            end
          end
        end
      end
      if (act_m[d]) begin
        if (chk) begin
          eb = exp_bit(e.b, k);
          vec++;
          if (tx_w[d] !== eb || ist_w[d] !== 1'b1
              || done_w[d] !== (k == len - 1)) begin
            err++;
            $display("FAIL frame_bit dut%0d byte %h k=%0d: tx=%b is_tx=%b done=%b, required %b 1 %b",
                     d, e.b, k, tx_w[d], ist_w[d], done_w[d], eb, (k == len - 1));
          end
          if (k == 0) begin
            vec++;
            if (rdy_w[d] !== 1'b1) begin
              err++;
              $display("FAIL ready_at_start dut%0d: got %b, required 1", d, rdy_w[d]);
            end
          end
        end
        if (k % BP == BP / 2 && k / BP >= 1 && k / BP <= 8)
          rx[k/BP-1] = tx_w[d];
        k++;
        if (k == len) begin
          act_m[d] = 1'b0;
          pend = cyc;
          if (chk) begin
            vec++;
            if (rx !== e.b) begin
              err++;
              $display("FAIL rx_byte dut%0d: got %h, required %h", d, rx, e.b);
            end
          end
        end
      end
    end
  endtask

  function automatic logic rst_w(input int d);
    return rst_r[d];
  endfunction

  task automatic send(input int d, input logic [7:0] b, output int acc);
    int   n;
    bit   ok;
    logic r;
    exp_t e;
    n = 0; ok = 0; acc = -1;
    @(negedge clk);
    trans_r[d] = 1'b1;
    byte_r[d]  = b;
    while (!ok && n < 400) begin
      r = rdy_w[d];
      @(posedge clk);
      #1;
      n++;
      if (r) ok = 1;
    end
    trans_r[d] = 1'b0;
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL send_timeout dut%0d byte %h: tx_ready stayed 0", d, b);
    end else begin
      acc = cyc;
      e.b = b; e.a = cyc;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      if (rdy_w[d] !== 1'b0) begin
        err++;
        $display("FAIL ready_drop dut%0d: got %b, required 0", d, rdy_w[d]);
      end
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((qsize(d) != 0 || act_m[d]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (n >= 3000) begin
      err++;
      $display("FAIL drain_timeout dut%0d: %0d frames pending", d, qsize(d));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, gap;
    logic [7:0] rb;
    byte_r[0] = 8'h00;
    byte_r[1] = 8'h00;
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) @(negedge clk);
    vec++;
    if (tx_w !== 2'b11 || rdy_w !== 2'b11 || ist_w !== 2'b00 || done_w !== 2'b00) begin
      err++;
      $display("FAIL reset_vals: tx=%b rdy=%b ist=%b done=%b, required 11 11 00 00",
               tx_w, rdy_w, ist_w, done_w);
    end
    rst_r = 2'b00;

    repeat (100) begin
      @(negedge clk);
      vec++;
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || ist_w[0] !== 1'b0) begin
        err++;
        $display("FAIL idle_hold: tx=%b rdy=%b ist=%b, required 1 1 0",
                 tx_w[0], rdy_w[0], ist_w[0]);
      end
    end

    send(0, 8'h55, a);
    drain(0);

    send(0, 8'hA3, a);
    send(0, 8'h0F, a);
    repeat (20) begin
      @(negedge clk);
      trans_r[0] = 1'b1;
      byte_r[0]  = 8'h77;
      vec++;
      if (rdy_w[0] !== 1'b0) begin
        err++;
        $display("FAIL ready_full: got %b, required 0", rdy_w[0]);
      end
    end
    trans_r[0] = 1'b0;
    drain(0);

    send(0, 8'h3C, a);
    send(0, 8'hC5, gap);
    while (cyc < a + 1 + 5 * BP + 3) @(negedge clk);
    #2;
    rst_r[0] = 1'b1;
    #1;
    vec++;
    if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || ist_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      err++;
      $display("FAIL async_rst: tx=%b rdy=%b ist=%b done=%b, required 1 1 0 0",
               tx_w[0], rdy_w[0], ist_w[0], done_w[0]);
    end
    q0.delete();
    repeat (3) @(negedge clk);
    rst_r[0] = 1'b0;
    send(0, 8'h00, a);
    drain(0);

    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
      repeat (gap) @(negedge clk);
      send(0, rb, a);
    end
    drain(0);

    send(1, 8'hFF, a);
    drain(1);
    send(1, 8'($urandom), a);
    send(1, 8'($urandom), a);
    drain(1);

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/txuart_buffered.md
Name: txuart_buffered

Overview:
- 8N1 (or 8N2) asynchronous serial transmitter: takes bytes over a valid/ready handshake and drives the idle-high serial line.
- Bit timing matches the team's receiver: the bit period is 4 prescaler ticks of CLOCK_DIVIDE clocks each.
- One-byte holding register in front of the shift register, so consecutive bytes go out back-to-back with no idle gap.
- Sits between the command/host logic and the board TX pin, opposite the receiver on the same link.

Parameters:
- CLOCK_DIVIDE, 312, clocks per quarter-bit tick (clock rate / (baud * 4)); legal range 1..2047.
- STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  master clock.
- rst  input  1  asynchronous, active-high reset.
- transmit  input  1  byte-valid strobe; sampled on rising clk edges.
- tx_byte  input  8  byte to send; captured when transmit && tx_ready.
- tx  output  1  serial line; idle high.
- tx_ready  output  1  high when the holding register is empty and a byte can be accepted.
- is_transmitting  output  1  high while any frame bit (start/data/stop) is being driven.
- tx_done  output  1  one-cycle pulse on the final clock of each frame's last stop bit.

Behaviour:
- Reset (async, rst=1): tx=1, tx_ready=1, is_transmitting=0, tx_done=0, state=TX_IDLE, holding empty, prescaler=0, tick count=0, bit count=0.
- Reset mid-frame aborts the frame immediately (tx forced high) and discards any held byte.
- All outputs are registered.
- Handshake:
  - Accept occurs when transmit=1 and tx_ready=1 on a clk edge: tx_byte goes into holding, and tx_ready drops the next cycle.
  - transmit while tx_ready=0 is ignored, with no state change and no corruption of the held byte.
  - tx_byte only needs to be stable on the accept edge.
- Holding to shifter: when the state machine is in TX_IDLE, or finishing the last stop bit, and holding is full, the byte moves to the shift register and holding empties.
  - tx_ready returns high on that same edge.
  - The shifter may then be busy while a second byte is held, so tx_ready=0 during that window.
- Timing:
  - The prescaler counts 0..CLOCK_DIVIDE-1 and produces a tick on the terminal count.
  - Each bit lasts exactly 4 ticks = 4*CLOCK_DIVIDE clocks.
  - The prescaler restarts at 0 at the first clock of each start bit; no fractional carry.
- State machine:
  - TX_IDLE: tx=1. If holding is full, load the shifter, set tx=0 (start bit), and go to TX_START.
  - TX_START: after 4 ticks, drive data bit 0 and go to TX_DATA with bit count 8.
  - TX_DATA: LSB first. After every 4 ticks, shift right and decrement the bit count; after the 8th bit, tx=1 and go to TX_STOP.
  - TX_STOP: lasts 4*STOP_BITS ticks. On the final clock, pulse tx_done. If holding is full, go directly to TX_START (tx=0 on the next clock, no idle gap); otherwise go to TX_IDLE.
- Latency: tx falls on the 2nd rising edge after the accept edge (accept to holding, then holding to shifter/start). Next-frame start after a back-to-back stop carries zero extra cycles.
- Frame length: (1 + 8 + STOP_BITS) * 4 * CLOCK_DIVIDE clocks.
- is_transmitting is 1 from the first clock of the start bit through the final stop clock. It stays 1 across back-to-back frames.
- Simultaneous events: an accept on the same edge that holding drains into the shifter is legal. The new byte fills holding and tx_ready falls the next cycle.
- Counter widths: prescaler 11 bits, tick counter 3 bits, bit counter 4 bits. No wrap beyond the stated ranges.

Test Plan (CLOCK_DIVIDE=2, STOP_BITS=1, bit period 8 clocks):
- Reset release, no transmit:
  - Tx=1, tx_ready=1, is_transmitting=0 held for 100 clocks.
- Single byte 0x55, accepted at cycle T:
  - tx=0 during cycles T+2..T+9.
  - Data 1,0,1,0,1,0,1,0 for 8 clocks each.
  - Stop high during T+74..T+81, with tx_done=1 only at T+81.
  - Tx_ready low only during cycle T+1.
- Back-to-back 0xA3 then 0x0F (second transmit held until accepted):
  - The 0x0F start bit begins on the clock after the 0xA3 tx_done.
  - Total 160 clocks of is_transmitting=1 with no idle cycle.
  - The receiver model decodes 0xA3, 0x0F.
- Third transmit while both shifter and holding are occupied:
  - Ignored.
  - Only two frames are emitted.
  - The held byte is unchanged.
- Async rst asserted mid-data bit 4, between clock edges:
  - Tx=1 and tx_ready=1 immediately.
  - No tx_done.
  - After release, byte 0x00 transmits correctly.
- STOP_BITS=2, byte 0xFF:
  - Stop high for 16 clocks.
  - Frame length 88 clocks.
  - tx_done on the final clock.
